// File: rtl/expr_stream_checker.sv
// rtl/expr_stream_checker.sv - streaming ASCII arithmetic-expression recognizer (optional parentheses via EXPR_PAREN_EN)
module expr_stream_checker #(
  parameter int         MAX_DIGITS = 4,
  parameter int         MAX_DEPTH  = 3,
  parameter logic [3:0] OP_MASK    = 4'b1111
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       restart,
  input  logic       in_valid,
  input  logic [7:0] in,
  output logic       out,
  output logic       err,
  output logic [3:0] depth,
  output logic [3:0] dcnt
);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_NUM   = 2'd1,
    S_CLOSE = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_CAP = 4'(MAX_DIGITS);
  localparam logic [3:0] DEPTH_CAP = 4'(MAX_DEPTH);

  state_t     state;
  logic [3:0] depth_q;
  logic [3:0] dcnt_q;

  logic is_digit;
  logic is_op;
  logic is_lp;
  logic is_rp;

  // Classify the incoming byte; masked-off operators and, without paren support, brackets fall through to OTHER
  always_comb begin
    is_digit = (in >= 8'h30) && (in <= 8'h39);
    is_op    = ((in == 8'h2B) && OP_MASK[0]) ||
               ((in == 8'h2D) && OP_MASK[1]) ||
               ((in == 8'h2A) && OP_MASK[2]) ||
               ((in == 8'h2F) && OP_MASK[3]);
`ifdef EXPR_PAREN_EN
    is_lp    = (in == 8'h28);
    is_rp    = (in == 8'h29);
`else
    is_lp    = 1'b0;
    is_rp    = 1'b0;
`endif
  end

  // Recognizer FSM with operand-length and nesting counters; ERR freezes everything until clr or restart
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= S_START;
      depth_q <= 4'd0;
      dcnt_q  <= 4'd0;
    end else if (restart) begin
      state   <= S_START;
      depth_q <= 4'd0;
      dcnt_q  <= 4'd0;
    end else if (in_valid) begin
      case (state)
        S_START: begin
          if (is_digit) begin
            state  <= S_NUM;
            dcnt_q <= 4'd1;
          end else if (is_lp) begin
            if (depth_q == DEPTH_CAP) state <= S_ERR;
            else                      depth_q <= depth_q + 4'd1;
          end else begin
            state <= S_ERR;
          end
        end
        S_NUM: begin
          if (is_digit) begin
            if (dcnt_q == DIGIT_CAP) state <= S_ERR;
            else                     dcnt_q <= dcnt_q + 4'd1;
          end else if (is_op) begin
            state  <= S_START;
            dcnt_q <= 4'd0;
          end else if (is_rp) begin
            if (depth_q == 4'd0) begin
              state <= S_ERR;
            end else begin
              depth_q <= depth_q - 4'd1;
              state   <= S_CLOSE;
              dcnt_q  <= 4'd0;
            end
          end else begin
            state <= S_ERR;
          end
        end
        S_CLOSE: begin
          if (is_op) begin
            state <= S_START;
          end else if (is_rp) begin
            if (depth_q == 4'd0) state <= S_ERR;
            else                 depth_q <= depth_q - 4'd1;
          end else begin
            state <= S_ERR;
          end
        end
        default: begin
          state <= S_ERR;
        end
      endcase
    end
  end

  assign err  = (state == S_ERR);
  assign dcnt = dcnt_q;
`ifdef EXPR_PAREN_EN
  assign out   = ((state == S_NUM) || (state == S_CLOSE)) && (depth_q == 4'd0);
  assign depth = depth_q;
`else
  assign out   = (state == S_NUM);
  assign depth = 4'd0;
`endif

endmodule
